// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   XLEN  : address / PC width
//   ILEN  : instruction word width
//   NOP   : canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_state_e : BOOT / RUN / HALT state of the fetch FSM
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// fetch_pc_reg
//   Program counter register and its next-PC selection.
//   Priority: reset > redirect > sequential step > hold.
//   Ports:
//     clk             in   rising-edge clock
//     reset           in   synchronous, active-low reset
//     redirect_en     in   load redirect_target this cycle
//     redirect_target in   new PC on redirect
//     step_en         in   advance PC by PC_STEP (wraps modulo 2^XLEN)
//     pc_q            out  current PC
// ---------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            step_en,
  output logic [XLEN-1:0] pc_q
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_en) begin
      pc_q <= redirect_target;
    end else if (step_en) begin
      pc_q <= pc_q + STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage: owns the PC (via fetch_pc_reg), drives the combinational
//   instruction memory address and captures the returned word into the IF/ID
//   register with a valid/ready handshake toward decode. Supports decode
//   back-pressure, branch/jump redirect and halt.
//   Optional feature macro: FETCH_MISALIGN_CHK_EN
//     When defined, a redirect whose target is not 4-byte aligned is refused:
//     the PC holds, the IF/ID register is emptied, misalign_fault is set
//     (sticky until reset) and the FSM enters HALT.
//   Ports:
//     clk, reset        clock, synchronous active-low reset
//     Inst_Address      fetch address (= current PC)
//     instruction       memory read data for Inst_Address, same cycle
//     id_ready          decode accepts if_instr this cycle
//     redirect_valid    branch/jump taken, redirect_target is the new PC
//     halt_req          stop fetching after the current cycle
//     if_valid/if_instr/if_pc   IF/ID register contents
//     halted            FSM is in HALT
//     misalign_fault    (macro only) refused misaligned redirect seen
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int unsigned     PC_STEP   = 4,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] Inst_Address,
  input  logic [ILEN-1:0] instruction,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            misalign_fault,
`endif
  output logic            halted
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            redirect_hit;
  logic            redirect_take;
  logic            load;
  logic            step_en;

  // Redirects are ignored while booting; otherwise they win over everything.
  assign redirect_hit = redirect_valid && (state_q != BOOT);

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_hit;
  assign misalign_hit  = redirect_hit && (redirect_target[1:0] != 2'b00);
  assign redirect_take = redirect_hit && !misalign_hit;
`else
  assign redirect_take = redirect_hit;
`endif

  // A new word is captured when running and the IF/ID slot is empty or being consumed.
  assign load    = (state_q == RUN) && (!if_valid || id_ready);
  // Any redirect attempt (taken or refused) suppresses the sequential step.
  assign step_en = load && !redirect_hit;

  assign Inst_Address = pc_q;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk             (clk),
    .reset           (reset),
    .redirect_en     (redirect_take),
    .redirect_target (redirect_target),
    .step_en         (step_en),
    .pc_q            (pc_q)
  );

  // FSM and IF/ID register. Redirect flushes the slot and resumes RUN;
  // otherwise the slot loads, stalls, or drains when consumed without reload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= BOOT;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      halted   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_fault <= 1'b0;
`endif
    end else if (redirect_take) begin
      state_q  <= RUN;
      halted   <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
    end else if (misalign_hit) begin
      state_q        <= HALT;
      halted         <= 1'b1;
      if_valid       <= 1'b0;
      if_instr       <= NOP_INSTR;
      misalign_fault <= 1'b1;
`endif
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (halt_req) begin
            state_q <= HALT;
            halted  <= 1'b1;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= BOOT;
      endcase

      if (load) begin
        if_valid <= 1'b1;
        if_instr <= instruction;
        if_pc    <= pc_q;
      end else if (if_valid && id_ready) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Self-checking bench for instruction_fetch_unit: directed vectors with
//   literal expectations plus a behavioural reference model compared on
//   every cycle.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] instruction;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        halt_req;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_fault;
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h1000_0000 ^ a[31:0];
  endfunction

  assign instruction = mem_word(Inst_Address);

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .Inst_Address    (Inst_Address),
    .instruction     (instruction),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_fault  (misalign_fault),
`endif
    .halted          (halted)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference model: a PC, a one-entry slot, and a running/halted/booting flag.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  bit          m_valid, m_fault, m_boot, m_halt;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP_W;
      m_valid = 0; m_fault = 0; m_boot = 1; m_halt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (redirect_valid && MIS_EN && redirect_target[1:0] != 2'b00) begin
      m_valid = 0; m_instr = NOP_W; m_fault = 1; m_halt = 1;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 0; m_instr = NOP_W; m_halt = 0;
    end else begin
      if (!m_halt && (!m_valid || id_ready)) begin
        m_ipc = m_pc; m_instr = mem_word(m_pc); m_valid = 1; m_pc = m_pc + 64'd4;
      end else if (m_valid && id_ready) begin
        m_valid = 0; m_instr = NOP_W;
      end
      if (halt_req) m_halt = 1;
    end
  end

  // Compare process: every cycle once the first reset edge has been seen.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("cyc_addr", Inst_Address, m_pc);
      checkOutput("cyc_valid", 64'(if_valid), 64'(m_valid));
      checkOutput("cyc_instr", 64'(if_instr), 64'(m_instr));
      checkOutput("cyc_halted", 64'(halted), 64'(m_halt));
      if (m_valid) checkOutput("cyc_pc", if_pc, m_ipc);
`ifdef FETCH_MISALIGN_CHK_EN
      checkOutput("cyc_fault", 64'(misalign_fault), 64'(m_fault));
`endif
    end
  end

  // Drive one cycle of inputs; return just after the following falling edge.
  task automatic applyStimulus(input bit rst_n, input bit rdy, input bit rv,
                               input logic [63:0] tgt, input bit hr);
    reset = rst_n; id_ready = rdy; redirect_valid = rv;
    redirect_target = tgt; halt_req = hr;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 1, 0, 64'h0, 0);
    checkOutput("rst_valid", 64'(if_valid), 64'h0);
    checkOutput("rst_addr", Inst_Address, 64'h0);
    checkOutput("rst_halted", 64'(halted), 64'h0);
    checkOutput("rst_instr", 64'(if_instr), 64'(NOP_W));
    checkOutput("rst_pc", if_pc, 64'h0);
  endtask

  initial begin
    reset = 0; id_ready = 1; redirect_valid = 0; redirect_target = '0; halt_req = 0;
    @(negedge clk);
    #1;
    armed = 1;

    // Test 1: boot cycle then back-to-back fetches
    doReset();
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t1_boot_valid", 64'(if_valid), 64'h0);
    checkOutput("t1_boot_addr", Inst_Address, 64'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 64'h0, 0);
      checkOutput("t1_valid", 64'(if_valid), 64'h1);
      checkOutput("t1_pc", if_pc, 64'(4 * i));
      checkOutput("t1_instr", 64'(if_instr), 64'(32'h1000_0000 + 32'(4 * i)));
    end
    checkOutput("t1_addr16", Inst_Address, 64'h10);

    // Test 2: three-cycle stall at if_pc=4
    doReset();
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 64'h0, 0);
      checkOutput("t2_stall_pc", if_pc, 64'h4);
      checkOutput("t2_stall_instr", 64'(if_instr), 64'h1000_0004);
      checkOutput("t2_stall_addr", Inst_Address, 64'h8);
      checkOutput("t2_stall_valid", 64'(if_valid), 64'h1);
    end
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t2_resume_pc", if_pc, 64'h8);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t2_next_pc", if_pc, 64'hC);

    // Test 3: redirect to 0x40 during stall beats the stall
    applyStimulus(1, 0, 1, 64'h40, 0);
    checkOutput("t3_bubble_valid", 64'(if_valid), 64'h0);
    checkOutput("t3_bubble_instr", 64'(if_instr), 64'(NOP_W));
    checkOutput("t3_addr", Inst_Address, 64'h40);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t3_target_pc", if_pc, 64'h40);
    checkOutput("t3_target_valid", 64'(if_valid), 64'h1);

    // Test 4: halt while stalled at pc_q=8, drain, then redirect back to 0
    doReset();
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 0, 0, 64'h0, 1);
    checkOutput("t4_halted", 64'(halted), 64'h1);
    checkOutput("t4_addr", Inst_Address, 64'h8);
    checkOutput("t4_held_valid", 64'(if_valid), 64'h1);
    applyStimulus(1, 0, 0, 64'h0, 0);
    checkOutput("t4_held_pc", if_pc, 64'h4);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t4_drained", 64'(if_valid), 64'h0);
    checkOutput("t4_addr_hold", Inst_Address, 64'h8);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t4_still_halted", 64'(halted), 64'h1);
    applyStimulus(1, 1, 1, 64'h0, 0);
    checkOutput("t4_unhalt", 64'(halted), 64'h0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t4_restart_pc", if_pc, 64'h0);
    checkOutput("t4_restart_valid", 64'(if_valid), 64'h1);

    // Test 5: reset mid-stall
    doReset();
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    applyStimulus(1, 0, 0, 64'h0, 0);
    applyStimulus(1, 0, 0, 64'h0, 0);
    applyStimulus(0, 0, 0, 64'h0, 0);
    checkOutput("t5_valid", 64'(if_valid), 64'h0);
    checkOutput("t5_addr", Inst_Address, 64'h0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t5_boot_valid", 64'(if_valid), 64'h0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t5_first_pc", if_pc, 64'h0);

    // Test 6: wrap at the top of the address space
    applyStimulus(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    checkOutput("t6_addr_top", Inst_Address, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t6_pc_top", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("t6_instr_top", 64'(if_instr), 64'hEFFF_FFFC);
    checkOutput("t6_wrap_addr", Inst_Address, 64'h0);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t6_wrap_pc", if_pc, 64'h0);

    // Misaligned redirect: refused with the check, loaded as-is without it
    applyStimulus(1, 1, 1, 64'h6, 0);
    checkOutput("t6_mis_valid", 64'(if_valid), 64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    checkOutput("t6_mis_fault", 64'(misalign_fault), 64'h1);
    checkOutput("t6_mis_halted", 64'(halted), 64'h1);
    checkOutput("t6_mis_addr", Inst_Address, 64'h4);
`else
    checkOutput("t6_mis_addr", Inst_Address, 64'h6);
`endif

    // Redirect and halt_req together: redirect wins
    applyStimulus(1, 1, 1, 64'h20, 1);
    checkOutput("t7_halted", 64'(halted), 64'h0);
    checkOutput("t7_addr", Inst_Address, 64'h20);
    applyStimulus(1, 1, 0, 64'h0, 0);
    checkOutput("t7_pc", if_pc, 64'h20);
    applyStimulus(1, 1, 0, 64'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
